// File: rtl/clock_monitor_pkg.sv
// Shared types and constants for the target-clock monitor.
package clock_monitor_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_STOPPED = 2'd3
  } state_e;

endpackage

// File: rtl/edge_synchronizer.sv
// Multi-flop synchronizer for an asynchronous level, plus a history flop
// that turns the synchronized level into single-cycle rise/fall strobes.
module edge_synchronizer
  import clock_monitor_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_async};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign o_level = sync_q[STAGES-1];
  assign o_rise  = sync_q[STAGES-1] & ~hist_q;
  assign o_fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of an asynchronous target clock in system
// clock cycles, flagging stopped clocks and sub-minimum pulses.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned MIN_PULSE = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_target,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_measured,
  output logic             o_valid,
  output logic             o_stopped,
  output logic             o_glitch
);

  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] MIN_C     = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_tmp_q, high_tmp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             seen_q, seen_d;
  logic             measured_q, measured_d;
  logic             valid_q, valid_d;
  logic             glitch_q, glitch_d;

  logic             tgt_rise, tgt_fall, tgt_level_unused;
  logic [WIDTH-1:0] low;
  logic             timeout;

  edge_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_target),
    .o_level (tgt_level_unused),
    .o_rise  (tgt_rise),
    .o_fall  (tgt_fall)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      high_tmp_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      seen_q     <= 1'b0;
      measured_q <= 1'b0;
      valid_q    <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_tmp_q <= high_tmp_d;
      period_q   <= period_d;
      high_q     <= high_d;
      seen_q     <= seen_d;
      measured_q <= measured_d;
      valid_q    <= valid_d;
      glitch_q   <= glitch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
    high_tmp_d = high_tmp_q;
    period_d   = period_q;
    high_d     = high_q;
    seen_d     = seen_q;
    measured_d = 1'b0;
    valid_d    = valid_q;
    glitch_d   = glitch_q;
    low        = cnt_q - high_tmp_q;
    timeout    = (cnt_q == TIMEOUT_C);

    if (!i_enable) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      seen_d   = 1'b0;
      valid_d  = 1'b0;
      glitch_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          cnt_d   = '0;
        end
        S_ARM: begin
          if (tgt_rise) begin
            state_d = S_MEASURE;
            cnt_d   = ONE;
            seen_d  = 1'b0;
          end else if (timeout) begin
            state_d = S_STOPPED;
            valid_d = 1'b0;
          end
        end
        S_MEASURE: begin
          if (tgt_fall) begin
            high_tmp_d = cnt_q;
            seen_d     = 1'b1;
          end
          // seen_q guards the first rise after ARM/STOPPED, which has no high time yet
          if (tgt_rise) begin
            cnt_d  = ONE;
            seen_d = 1'b0;
            if (seen_q) begin
              if (high_tmp_q >= MIN_C && low >= MIN_C) begin
                period_d   = cnt_q;
                high_d     = high_tmp_q;
                measured_d = 1'b1;
                valid_d    = 1'b1;
              end else begin
                glitch_d = 1'b1;
              end
            end
          end else if (timeout) begin
            state_d = S_STOPPED;
            valid_d = 1'b0;
          end
        end
        S_STOPPED: begin
          if (tgt_rise) begin
            state_d = S_MEASURE;
            cnt_d   = ONE;
            seen_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_period   = period_q;
  assign o_high     = high_q;
  assign o_measured = measured_q;
  assign o_valid    = valid_q;
  assign o_stopped  = (state_q == S_STOPPED);
  assign o_glitch   = glitch_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: waveform-driven scenarios checked every cycle
// against a timestamp-based reference model.
module tb_clock_monitor;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned TIMEOUT   = 50;
  localparam int unsigned MIN_PULSE = 2;

  logic             i_clock = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_enable = 1'b0;
  logic             i_target = 1'b0;
  logic [WIDTH-1:0] o_period, o_high;
  logic             o_measured, o_valid, o_stopped, o_glitch;

  int checks = 0;
  int errors = 0;

  clock_monitor #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .MIN_PULSE(MIN_PULSE)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_target   (i_target),
    .o_period   (o_period),
    .o_high     (o_high),
    .o_measured (o_measured),
    .o_valid    (o_valid),
    .o_stopped  (o_stopped),
    .o_glitch   (o_glitch)
  );

  always #5 i_clock = ~i_clock;

  // Reference model: events are timestamps in system cycles; a target level
  // sampled at edge n is seen as an edge by the monitor at edge n+2.
  int               m_mode = 0;      // 0 idle, 1 arm, 2 measure, 3 stopped
  int unsigned      n = 8, t0 = 0, fall_t = 0;
  bit               have_fall = 1'b0;
  bit [7:0]         hist = '0;
  bit               m_rise, m_fall;
  logic [WIDTH-1:0] m_period = '0, m_high = '0;
  logic             m_measured = 1'b0, m_valid = 1'b0, m_glitch = 1'b0;
  logic             m_stopped;
  assign m_stopped = (m_mode == 3);

  logic [2*WIDTH+3:0] obs, exp_v;
  assign obs   = {o_period, o_high, o_measured, o_valid, o_stopped, o_glitch};
  assign exp_v = {m_period, m_high, m_measured, m_valid, m_stopped, m_glitch};

  initial forever begin
    @(posedge i_clock or posedge i_reset);
    if (i_reset) begin
      m_mode = 0; n = 8; t0 = 0; fall_t = 0; have_fall = 1'b0; hist = '0;
      m_period = '0; m_high = '0; m_measured = 1'b0; m_valid = 1'b0; m_glitch = 1'b0;
    end else begin
      n++;
      hist[3'(n)] = i_target;
      m_rise = hist[3'(n-2)] & ~hist[3'(n-3)];
      m_fall = ~hist[3'(n-2)] & hist[3'(n-3)];
      m_measured = 1'b0;
      if (!i_enable) begin
        m_mode = 0; m_valid = 1'b0; m_glitch = 1'b0;
      end else begin
        case (m_mode)
          0: begin m_mode = 1; t0 = n + 1; end
          1: if (m_rise) begin m_mode = 2; t0 = n; have_fall = 1'b0; end
             else if (n - t0 == TIMEOUT) begin m_mode = 3; m_valid = 1'b0; end
          2: begin
            if (m_fall) begin fall_t = n; have_fall = 1'b1; end
            if (m_rise) begin
              if (have_fall) begin
                if ((fall_t - t0) >= MIN_PULSE && (n - fall_t) >= MIN_PULSE) begin
                  m_period = WIDTH'(n - t0); m_high = WIDTH'(fall_t - t0);
                  m_measured = 1'b1; m_valid = 1'b1;
                end else m_glitch = 1'b1;
              end
              t0 = n; have_fall = 1'b0;
            end else if (n - t0 == TIMEOUT) begin m_mode = 3; m_valid = 1'b0; end
          end
          default: if (m_rise) begin m_mode = 2; t0 = n; have_fall = 1'b0; end
        endcase
      end
    end
  end

  // Stimulus: each entry is {enable, target} for one system cycle.
  logic [1:0] wave[$];

  task automatic add_level(input logic lvl, input int unsigned cyc, input logic en = 1'b1);
    for (int unsigned k = 0; k < cyc; k++) wave.push_back({en, lvl});
  endtask

  task automatic add_periods(input int unsigned p, input int unsigned h, input int unsigned cnt);
    for (int unsigned k = 0; k < cnt; k++) begin
      add_level(1'b1, h);
      add_level(1'b0, p - h);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    repeat (2) @(negedge i_clock);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_held got=%h exp=0", obs); end
    i_reset = 1'b0;
  endtask

  task automatic test_basic();
    wave.delete(); add_periods(10, 5, 4);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL basic[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
    @(negedge i_clock); checks++;
    if (o_period !== 16'd10 || o_high !== 16'd5 || o_valid !== 1'b1 || o_stopped !== 1'b0 || o_glitch !== 1'b0) begin
      errors++; $display("FAIL basic_final got p=%0d h=%0d v=%b s=%b g=%b exp p=10 h=5 v=1 s=0 g=0",
                         o_period, o_high, o_valid, o_stopped, o_glitch);
    end
  endtask

  task automatic test_change();
    wave.delete(); add_periods(12, 3, 5); add_periods(8, 4, 5);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL change[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
    @(negedge i_clock); checks++;
    if (o_period !== 16'd8 || o_high !== 16'd4) begin
      errors++; $display("FAIL change_final got p=%0d h=%0d exp p=8 h=4", o_period, o_high);
    end
  endtask

  task automatic test_timeout();
    wave.delete(); add_level(1'b0, 60);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL timeout[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
    checks++;
    if (o_stopped !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_stopped got s=%b v=%b exp s=1 v=0", o_stopped, o_valid);
    end
    wave.delete(); add_periods(10, 5, 3);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL restart[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
    checks++;
    if (o_stopped !== 1'b0 || o_valid !== 1'b1) begin
      errors++; $display("FAIL restart_final got s=%b v=%b exp s=0 v=1", o_stopped, o_valid);
    end
  endtask

  task automatic test_glitch();
    wave.delete(); add_periods(10, 5, 2);
    add_level(1'b1, 5); add_level(1'b0, 1); add_level(1'b1, 1); add_level(1'b0, 3);
    add_periods(10, 5, 3);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL glitch[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
    checks++;
    if (o_glitch !== 1'b1 || o_period !== 16'd10) begin
      errors++; $display("FAIL glitch_sticky got g=%b p=%0d exp g=1 p=10", o_glitch, o_period);
    end
    wave.delete(); add_level(1'b0, 1, 1'b0); add_level(1'b0, 1);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL glitch_clr[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
    @(negedge i_clock); checks++;
    if (o_glitch !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_cleared got g=%b v=%b exp g=0 v=0", o_glitch, o_valid);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned pulses = 0;
    wave.delete(); add_periods(10, 5, 2); add_level(1'b1, 4);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pre_reset[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
    @(negedge i_clock); #2 i_reset = 1'b1; i_target = 1'b0;
    #1 checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_mid got=%h exp=0", obs); end
    @(negedge i_clock); i_reset = 1'b0;
    wave.delete(); add_periods(10, 5, 4);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL post_reset[%0d] got=%h exp=%h", i, obs, exp_v); end
      if (o_measured === 1'b1) pulses++;
      {i_enable, i_target} = wave[i];
    end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL post_reset_pulses got=%0d exp=3", pulses); end
  endtask

  task automatic test_timeout_coincident();
    wave.delete(); add_periods(TIMEOUT, TIMEOUT / 2, 4);
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL coincident[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
    checks++;
    if (o_period !== 16'(TIMEOUT) || o_stopped !== 1'b0 || o_valid !== 1'b1) begin
      errors++; $display("FAIL coincident_final got p=%0d s=%b v=%b exp p=%0d s=0 v=1",
                         o_period, o_stopped, o_valid, TIMEOUT);
    end
  endtask

  task automatic test_random();
    wave.delete();
    for (int unsigned s = 0; s < 40; s++) begin
      int unsigned p = $urandom_range(70, 2);
      int unsigned h = $urandom_range(p - 1, 1);
      if ($urandom_range(7, 0) == 0) add_level(1'b0, $urandom_range(3, 1), 1'b0);
      add_periods(p, h, $urandom_range(3, 1));
    end
    foreach (wave[i]) begin
      @(negedge i_clock); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random[%0d] got=%h exp=%h", i, obs, exp_v); end
      {i_enable, i_target} = wave[i];
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_timeout_coincident();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Receive-side counterpart of the gated clock generator.
- Samples an asynchronous target clock in the system clock domain and measures its period and high time in system-clock cycles.
- Flags stopped (gated-off) clocks and short pulses (glitches).
- Used to check gated clock sources at runtime and in benches.

Parameters:
WIDTH, 16, width of period/high counters and result outputs
TIMEOUT, 1000, cycles without a target rising edge before o_stopped asserts (must be < 2^WIDTH)
MIN_PULSE, 2, minimum legal high or low time in cycles; shorter marks a glitch

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_reset  input  1  asynchronous active-high reset
i_enable  input  1  monitor enable
i_target  input  1  monitored clock, asynchronous to i_clock
o_period  output  WIDTH  last measured rise-to-rise period, cycles
o_high  output  WIDTH  last measured rise-to-fall high time, cycles
o_measured  output  1  one-cycle pulse when o_period/o_high update
o_valid  output  1  at least one good period measured since arm
o_stopped  output  1  no target rise for TIMEOUT cycles
o_glitch  output  1  sticky: pulse shorter than MIN_PULSE seen

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, synchronizer flops 0.
- Input path:
  - i_target passes through a 2-flop synchronizer (s1, s2), then a history flop p.
  - rise = s2 & ~p; fall = ~s2 & p.
  - Edge-to-detect latency is 3 i_clock cycles.
- Counter cnt:
  - cnt <= 1 on a rise cycle.
  - Otherwise cnt increments and saturates at 2^WIDTH-1.
  - Cleared to 0 in IDLE.
- States:
  - IDLE: i_enable=0. Counter cleared; o_valid, o_stopped, o_glitch cleared; o_period/o_high hold their last values. i_enable=1 -> ARM.
  - ARM: wait for first rise. rise -> MEASURE with cnt<=1, and high_tmp not yet captured. cnt reaching TIMEOUT -> STOPPED.
  - MEASURE:
    - fall: high_tmp<=cnt.
    - next rise: period=cnt, low=cnt-high_tmp.
      - If high_tmp>=MIN_PULSE and low>=MIN_PULSE: o_period<=cnt, o_high<=high_tmp, o_measured=1 for one cycle, o_valid<=1.
      - Otherwise: o_glitch<=1, outputs unchanged, no o_measured.
      - Either way cnt<=1 and the state stays MEASURE.
    - A rise with no fall since the previous rise is impossible after synchronization and needs no handling.
    - cnt reaching TIMEOUT -> STOPPED.
  - STOPPED: o_stopped=1, o_valid<=0. rise -> MEASURE, cnt<=1, o_stopped<=0. o_valid re-asserts only after the next full good period.
- Simultaneous events:
  - rise and cnt==TIMEOUT in the same cycle: rise wins, no stop.
  - i_enable falling takes priority over everything: -> IDLE next cycle, and any in-flight measurement is discarded.
- Reset asserted mid-measurement returns to the reset values immediately (asynchronous). Measurement restarts from ARM after release, once i_enable=1.
- Target held high when TIMEOUT expires is still "stopped". Fall alone does not clear it.
- Signedness: low=cnt-high_tmp is unsigned WIDTH bits; high_tmp<cnt is guaranteed.

Decomposition:
- Package clock_monitor_pkg:
  - state enum (IDLE, ARM, MEASURE, STOPPED) and its 2-bit width constant.
  - Synchronizer depth constant SYNC_STAGES=2.
- Sub-module edge_synchronizer:
  - 2-flop synchronizer plus history flop, with async reset.
  - Outputs o_level, o_rise, o_fall.
  - Reusable for other async inputs.

Test Plan:
- Reset, i_enable=1, target period 10 cycles, high 5, driven synchronously -> after the second detected rise: o_period=10, o_high=5, o_measured one-cycle pulse, o_valid=1, o_stopped=0, o_glitch=0.
- Target period 12, high 3, for 5 periods -> each rise after the first pulses o_measured with o_period=12, o_high=3. Then change to period 8, high 4 -> o_period=8, o_high=4 from the second new rise.
- Stop the target low with TIMEOUT=50 -> o_stopped=1 and o_valid=0 exactly 50 cycles after the last detected rise. Restart at period 10 -> o_stopped=0 on the first rise; o_valid=1 on the second rise.
- MIN_PULSE=2, inject a 1-cycle high pulse within a period-10 stream -> o_glitch=1 (sticky), o_period keeps 10, no o_measured for the glitched rise. i_enable low for 1 cycle -> o_glitch=0.
- Assert i_reset mid-period -> all outputs 0 in the same cycle. Release with i_enable=1 -> first o_measured after two detected rises.
- TIMEOUT rise-coincident: make a rise detect exactly when cnt==TIMEOUT -> o_stopped stays 0, o_period=TIMEOUT, o_measured pulses.
